crossfade_ramp: RTL and testbench
=================================

CROSSFADE_RAMP -- requirements
Module: crossfade_ramp

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 16, meaning the number of sample_tick_i pulses per one-LSB level step (legal range 1..256).
REQ-002 The block SHALL have parameter INIT_LEVEL, default 128, meaning the level_o and target value after reset.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-004 The block SHALL have port srst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port sample_tick_i, input, 1 bit: one-cycle audio sample strobe.
REQ-006 The block SHALL have port target_i, input, 8 bits: requested crossfade level, unsigned.
REQ-007 The block SHALL have port target_valid_i, input, 1 bit: target_i is accepted on every cycle this is high, with no backpressure.
REQ-008 The block SHALL have port level_o, output, 8 bits: registered level that drives the crossfader level input.
REQ-009 The block SHALL have port busy_o, output, 1 bit: high while a ramp is in progress.
REQ-010 The block SHALL have port done_o, output, 1 bit: one-cycle pulse on ramp completion.

Function
REQ-011 The block SHALL latch target_i into an internal target register on each cycle target_valid_i=1; the latched value is used by the FSM from the next cycle.
REQ-012 The FSM SHALL have three states: IDLE, UP and DOWN.
REQ-013 The FSM SHALL make the following transitions, each evaluated against the registered target and level:
- IDLE -> UP if target>level.
- IDLE -> DOWN if target<level.
- Otherwise it stays in IDLE.
REQ-014 In UP or DOWN, the FSM SHALL change direction immediately when a new registered target lies on the other side of level_o.
REQ-015 In UP or DOWN, when level_o equals target, the FSM SHALL go to IDLE.
REQ-016 The divider counter SHALL count sample_tick_i pulses only while in UP or DOWN, over the range 0..TICK_DIV-1. On a tick with counter=TICK_DIV-1 it SHALL:
- Step level_o by +1 in UP or -1 in DOWN.
- Clear the counter.
REQ-017 The divider counter SHALL clear on entry to IDLE and SHALL be retained across a direction change.
REQ-018 level_o SHALL saturate at 0 and 255 and SHALL never wrap.
REQ-019 If a step and a target_valid_i occur in the same cycle, the step SHALL follow the current state and the new target SHALL take effect the following cycle. One LSB of overshoot is permitted; the ramp then reverses.
REQ-020 busy_o SHALL equal (state != IDLE), registered with state.
REQ-021 done_o SHALL pulse high for exactly one cycle, in the cycle after a UP/DOWN->IDLE transition.
REQ-022 A target equal to level_o while in IDLE SHALL produce neither busy_o nor done_o.
REQ-023 A full-scale ramp SHALL take 255*TICK_DIV sample ticks.
REQ-024 With no sample_tick_i pulses, level_o SHALL hold its value indefinitely.

Reset
REQ-025 While srst_i=1, the block SHALL force the following values at the next clock edge:
- level_o=INIT_LEVEL and target=INIT_LEVEL.
- state=IDLE and counter=0.
- busy_o=0 and done_o=0.
REQ-026 A reset asserted mid-ramp SHALL abort the ramp without a done_o pulse; srst_i SHALL take priority over all inputs.

Configuration
REQ-027 With macro CROSSFADE_RAMP_SNAP_EN defined, the block SHALL have an additional 1-bit input snap_i. When snap_i=1 and target_valid_i=1 are sampled together:
- level_o and target SHALL load target_i at the next edge.
- state SHALL go to IDLE and the counter SHALL clear.
- done_o SHALL NOT pulse.
REQ-028 Without CROSSFADE_RAMP_SNAP_EN, snap_i SHALL be absent and every target SHALL ramp.

Verification (TICK_DIV=4, INIT_LEVEL=128 unless noted)
REQ-029 Scenario 1: target_i=132 with continuous ticks -> level_o steps 129,130,131,132 every 4 ticks; after 16 ticks busy_o falls and done_o is high for 1 cycle.
REQ-030 Scenario 2: TICK_DIV=1, target_i=0 -> level_o reaches 0 after 128 ticks; further ticks hold 0; no wrap to 255.
REQ-031 Scenario 3: target_i=140, then target_i=130 when level_o=134 -> level_o descends to 130; exactly one done_o pulse in total.
REQ-032 Scenario 4: srst_i pulsed while level_o=135 during a ramp -> next cycle level_o=128, busy_o=0, and done_o stays 0.
REQ-033 Scenario 5: target_i=200, then sample_tick_i is held low for 1000 cycles -> busy_o=1 and level_o stays 128.
REQ-034 Scenario 6: with CROSSFADE_RAMP_SNAP_EN defined, snap_i=1 and target_i=10 during a ramp -> next cycle level_o=10, busy_o=0, and done_o=0.

Source files
------------

// File: rtl/crossfade_ramp.sv
// crossfade_ramp
// Slews an 8-bit crossfader level toward a requested target, one LSB every
// TICK_DIV audio sample ticks. A three-state FSM (IDLE / UP / DOWN) tracks
// whether a ramp is active and in which direction. busy_o is high while ramping,
// and done_o pulses for one cycle when a ramp finishes on its own.
//
// Optional build feature: define CROSSFADE_RAMP_SNAP_EN to add the snap_i input.
// When snap_i and target_valid_i are both high, the level jumps straight to
// target_i. No ramp follows and done_o does not pulse. The default build (macro
// undefined) has no snap_i port, and every target ramps.
//
// TICK_DIV legal range: 1..256. INIT_LEVEL is the level and target after reset.

module crossfade_ramp #(
    parameter int TICK_DIV   = 16,
    parameter int INIT_LEVEL = 128
) (
    input  logic       clk_i,
    input  logic       srst_i,
    input  logic       sample_tick_i,
    input  logic [7:0] target_i,
`ifdef CROSSFADE_RAMP_SNAP_EN
    input  logic       snap_i,
`endif
    input  logic       target_valid_i,
    output logic [7:0] level_o,
    output logic       busy_o,
    output logic       done_o
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    // The divider needs at least one bit, even when TICK_DIV is 1.
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [7:0]       INIT_L   = 8'(INIT_LEVEL);
    localparam logic [7:0]       LEVEL_MAX = 8'hFF;
    localparam logic [7:0]       LEVEL_MIN = 8'h00;

    // FSM state encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] UP   = 2'd1;
    localparam logic [1:0] DOWN = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]       state_reg,  state_next;
    logic [7:0]       level_reg,  level_next;
    logic [7:0]       target_reg, target_next;
    logic [CNT_W-1:0] cnt_reg,    cnt_next;
    logic             busy_reg,   busy_next;
    logic             done_reg,   done_next;

    // ------------------------------------------------------------------
    // Decode helpers
    // ------------------------------------------------------------------
    logic       target_above;   // registered target is above the level
    logic       target_below;   // registered target is below the level
    logic       at_target;      // level has reached the registered target
    logic       ramping;        // FSM is in UP or DOWN
    logic       step_due;       // this tick completes a divider period
    logic       snap_load;      // immediate load requested this cycle
    logic [7:0] level_inc;      // level + 1, held at full scale
    logic [7:0] level_dec;      // level - 1, held at zero

    // Comparisons always use the registered target, so a new target_i
    // takes effect from the cycle after it is accepted.
    assign target_above = (target_reg > level_reg);
    assign target_below = (target_reg < level_reg);
    assign at_target    = (target_reg == level_reg);
    assign ramping      = (state_reg == UP) || (state_reg == DOWN);
    assign step_due     = sample_tick_i && (cnt_reg == CNT_MAX);

`ifdef CROSSFADE_RAMP_SNAP_EN
    assign snap_load = snap_i && target_valid_i;
`else
    assign snap_load = 1'b0;
`endif

    // Saturating neighbours of the current level. The level can never wrap.
    assign level_inc = (level_reg == LEVEL_MAX) ? LEVEL_MAX : (level_reg + 8'd1);
    assign level_dec = (level_reg == LEVEL_MIN) ? LEVEL_MIN : (level_reg - 8'd1);

    // ------------------------------------------------------------------
    // Target register: accept target_i on every valid cycle, no backpressure
    // ------------------------------------------------------------------
    always_comb begin
        target_next = target_reg;
        if (target_valid_i) begin
            target_next = target_i;
        end
    end

    // ------------------------------------------------------------------
    // FSM, divider counter and level stepping
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        level_next = level_reg;

        case (state_reg)
            IDLE: begin
                // The divider stays clear while idle. Ticks are ignored here.
                cnt_next = CNT_ZERO;
                if (target_above) begin
                    state_next = UP;
                end else if (target_below) begin
                    state_next = DOWN;
                end
            end

            UP, DOWN: begin
                if (at_target) begin
                    // Ramp finished: return to idle with a fresh divider.
                    state_next = IDLE;
                    cnt_next   = CNT_ZERO;
                end else begin
                    // The direction follows the registered target, so a
                    // target on the other side of the level reverses the ramp
                    // at once. The divider phase is kept across the reversal.
                    state_next = target_above ? UP : DOWN;
                    if (sample_tick_i) begin
                        if (step_due) begin
                            cnt_next   = CNT_ZERO;
                            level_next = target_above ? level_inc : level_dec;
                        end else begin
                            cnt_next = cnt_reg + CNT_ONE;
                        end
                    end
                end
            end

            default: begin
                // Unreachable encoding: recover to a clean idle state.
                state_next = IDLE;
                cnt_next   = CNT_ZERO;
            end
        endcase

        // A snap load overrides the ramp completely. The level jumps to the
        // new target and the FSM parks in IDLE.
        if (snap_load) begin
            state_next = IDLE;
            cnt_next   = CNT_ZERO;
            level_next = target_i;
        end
    end

    // ------------------------------------------------------------------
    // Status flags, registered alongside the state
    // ------------------------------------------------------------------
    always_comb begin
        busy_next = (state_next != IDLE);
        // done_o marks only a ramp that finished on its own. A snap load
        // forces IDLE as well, but it does not count as a completion.
        done_next = ramping && (state_next == IDLE) && !snap_load;
    end

    // ------------------------------------------------------------------
    // Registers: reset takes priority over every other input
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_reg  <= IDLE;
            level_reg  <= INIT_L;
            target_reg <= INIT_L;
            cnt_reg    <= CNT_ZERO;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            level_reg  <= level_next;
            target_reg <= target_next;
            cnt_reg    <= cnt_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign level_o = level_reg;
    assign busy_o  = busy_reg;
    assign done_o  = done_reg;

endmodule

// File: tb/tb_crossfade_ramp.sv
// Testbench for crossfade_ramp.
// Two instances share the same stimulus: one with TICK_DIV=4 and one with
// TICK_DIV=1. A behavioural model of each instance is compared with the DUT on
// every cycle. Directed scenarios add literal expectations, and a randomized
// phase follows them.
// When CROSSFADE_RAMP_SNAP_EN is defined, the snap input is also exercised.

module tb_crossfade_ramp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       srst  = 1'b1;
    logic       tick  = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] tgt   = 8'd0;
    logic       snap  = 1'b0;

    logic [7:0] level_w [2];
    logic       busy_w  [2];
    logic       done_w  [2];

    crossfade_ramp #(.TICK_DIV(4), .INIT_LEVEL(128)) dut0 (
        .clk_i(clk), .srst_i(srst), .sample_tick_i(tick), .target_i(tgt),
`ifdef CROSSFADE_RAMP_SNAP_EN
        .snap_i(snap),
`endif
        .target_valid_i(valid), .level_o(level_w[0]), .busy_o(busy_w[0]),
        .done_o(done_w[0])
    );

    crossfade_ramp #(.TICK_DIV(1), .INIT_LEVEL(128)) dut1 (
        .clk_i(clk), .srst_i(srst), .sample_tick_i(tick), .target_i(tgt),
`ifdef CROSSFADE_RAMP_SNAP_EN
        .snap_i(snap),
`endif
        .target_valid_i(valid), .level_o(level_w[1]), .busy_o(busy_w[1]),
        .done_o(done_w[1])
    );

    int tests = 0;
    int fails = 0;

    // Behavioural model state for each instance
    int m_level [2];
    int m_target[2];
    int m_ticks [2];   // ticks collected toward the next one-LSB step
    bit m_busy  [2];
    bit m_done  [2];
    bit m_ok = 1'b0;   // model is meaningful once a reset has been applied

    function automatic int tdiv(int k);
        return (k == 0) ? 4 : 1;
    endfunction

    task automatic check(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Update the model for one clock edge, using the inputs held across that edge.
    // Rules: after a target differs from the level, the ramp starts one cycle
    // later. It moves one LSB toward the registered target every tdiv ticks. One
    // cycle after it reaches the target, it ends with a done pulse. A new target
    // is seen one cycle after it is accepted.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (srst) begin
                m_level[k] = 128; m_target[k] = 128; m_ticks[k] = 0;
                m_busy[k] = 0; m_done[k] = 0;
            end else if (snap && valid) begin
                m_level[k] = tgt; m_target[k] = tgt; m_ticks[k] = 0;
                m_busy[k] = 0; m_done[k] = 0;
            end else begin
                m_done[k] = 0;
                if (!m_busy[k]) begin
                    m_busy[k] = (m_target[k] != m_level[k]);
                end else if (m_level[k] == m_target[k]) begin
                    m_busy[k] = 0; m_done[k] = 1; m_ticks[k] = 0;
                end else if (tick) begin
                    m_ticks[k]++;
                    if (m_ticks[k] == tdiv(k)) begin
                        m_ticks[k] = 0;
                        m_level[k] += (m_target[k] > m_level[k]) ? 1 : -1;
                    end
                end
                if (valid) m_target[k] = tgt;
            end
        end
        if (srst) m_ok = 1'b1;
    endtask

    // One clock: update the model at the edge, then compare on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (m_ok) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("dut%0d.level", k), int'(level_w[k]), m_level[k]);
                check($sformatf("dut%0d.busy", k), int'(busy_w[k]), int'(m_busy[k]));
                check($sformatf("dut%0d.done", k), int'(done_w[k]), int'(m_done[k]));
            end
        end
    endtask

    task automatic do_reset();
        srst = 1'b1; valid = 1'b0; tick = 1'b0; snap = 1'b0;
        cycle(); cycle();
        srst = 1'b0;
    endtask

    task automatic send_target(input int v);
        valid = 1'b1; tgt = 8'(v);
        $display("[TB] target %0d accepted, dut0 level %0d", v, level_w[0]);
        cycle();
        valid = 1'b0;
    endtask

    initial begin
        int cnt_a, cnt_b, prev, steps, bad_step, wrap, hit;

        // ---------------- Reset state, and a target equal to the level
        do_reset();
        check("reset.level", int'(level_w[0]), 128);
        check("reset.busy", int'(busy_w[0]), 0);
        check("reset.done", int'(done_w[0]), 0);
        tick = 1'b1;
        send_target(128);
        cnt_a = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            cnt_a += int'(busy_w[0]) + int'(done_w[0]);
        end
        check("eq_target.no_activity", cnt_a, 0);

        // ---------------- Scenario 1: ramp up to 132
        do_reset();
        send_target(132);
        tick = 1'b1;
        cnt_a = 0; cnt_b = 0; steps = 0; bad_step = 0; prev = int'(level_w[0]);
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (busy_w[0] && level_w[0] != 8'd132) cnt_a++;
            if (done_w[0]) cnt_b++;
            if (int'(level_w[0]) != prev) begin
                steps++;
                if (int'(level_w[0]) != prev + 1) bad_step++;
                prev = int'(level_w[0]);
            end
        end
        check("s1.ramp_cycles", cnt_a, 16);
        check("s1.done_pulses", cnt_b, 1);
        check("s1.steps", steps, 4);
        check("s1.bad_steps", bad_step, 0);
        check("s1.final", int'(level_w[0]), 132);
        check("s1.model_final", m_level[0], 132);

        // ---------------- Scenario 2: ramp down to 0 and hold there
        do_reset();
        send_target(0);
        tick = 1'b1;
        cnt_a = 0; wrap = 0;
        for (int i = 0; i < 600; i++) begin
            cycle();
            if (busy_w[1] && level_w[1] != 8'd0) cnt_a++;
            if (level_w[0] == 8'd255 || level_w[1] == 8'd255) wrap = 1;
        end
        check("s2.ticks_to_zero", cnt_a, 128);
        check("s2.dut1_final", int'(level_w[1]), 0);
        check("s2.dut0_final", int'(level_w[0]), 0);
        check("s2.no_wrap", wrap, 0);

        // ---------------- Scenario 3: retarget down while ramping up
        do_reset();
        send_target(140);
        tick = 1'b1;
        cnt_b = 0; hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            cycle();
            if (done_w[0]) cnt_b++;
            if (level_w[0] == 8'd134) hit = 1;
        end
        check("s3.reach_134", hit, 1);
        send_target(130);
        if (done_w[0]) cnt_b++;
        for (int i = 0; i < 200; i++) begin
            cycle();
            if (done_w[0]) cnt_b++;
        end
        check("s3.done_pulses", cnt_b, 1);
        check("s3.final", int'(level_w[0]), 130);

        // ---------------- Scenario 4: reset in the middle of a ramp
        do_reset();
        send_target(140);
        tick = 1'b1;
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            cycle();
            if (level_w[0] == 8'd135) hit = 1;
        end
        check("s4.reach_135", hit, 1);
        srst = 1'b1;
        cycle();
        srst = 1'b0;
        check("s4.level", int'(level_w[0]), 128);
        check("s4.busy", int'(busy_w[0]), 0);
        check("s4.done", int'(done_w[0]), 0);
        cnt_b = 0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            cnt_b += int'(done_w[0]) + int'(busy_w[0]);
        end
        check("s4.quiet_after", cnt_b, 0);

        // ---------------- Scenario 5: no ticks means the level holds
        do_reset();
        tick = 1'b0;
        send_target(200);
        for (int i = 0; i < 1000; i++) cycle();
        check("s5.busy", int'(busy_w[0]), 1);
        check("s5.level", int'(level_w[0]), 128);

`ifdef CROSSFADE_RAMP_SNAP_EN
        // ---------------- Scenario 6: snap during a ramp
        do_reset();
        send_target(140);
        tick = 1'b1;
        for (int i = 0; i < 20; i++) cycle();
        snap = 1'b1; valid = 1'b1; tgt = 8'd10;
        $display("[TB] snap target 10 accepted, dut0 level %0d", level_w[0]);
        cycle();
        snap = 1'b0; valid = 1'b0;
        check("s6.level", int'(level_w[0]), 10);
        check("s6.busy", int'(busy_w[0]), 0);
        check("s6.done", int'(done_w[0]), 0);
        cnt_b = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            cnt_b += int'(done_w[0]);
        end
        check("s6.no_done", cnt_b, 0);
`endif

        // ---------------- Randomized phase
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int v;
            srst  = ($urandom_range(0, 499) == 0);
            tick  = $urandom_range(0, 1) != 0;
            valid = ($urandom_range(0, 29) == 0);
            snap  = 1'b0;
            if ($urandom_range(0, 1) != 0) begin
                v = int'($urandom_range(0, 255));
            end else begin
                v = m_level[0] + int'($urandom_range(0, 12)) - 6;
                if (v < 0) v = 0;
                if (v > 255) v = 255;
            end
            tgt = 8'(v);
`ifdef CROSSFADE_RAMP_SNAP_EN
            snap = valid && ($urandom_range(0, 4) == 0);
`endif
            if (valid)
                $display("[TB] rand target %0d (snap %0d), dut0 level %0d", v, snap, level_w[0]);
            cycle();
        end
        srst = 1'b0; valid = 1'b0; snap = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
